video_pattern_scheduler: RTL and testbench

VIDEO_PATTERN_SCHEDULER -- requirements
Module: video_pattern_scheduler

---
 rtl/video_pattern_scheduler.sv | 122 ++++++++++++
 tb/tb_video_pattern_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_scheduler.sv
// Frame-synchronous test-pattern sequencer: steps the pattern index on a vsync edge after a request.
// Optional backward stepping through input `prev` when VIDEO_PATTERN_SCHEDULER_PREV_EN is defined.
module video_pattern_scheduler #(
    parameter int PATTERNS = 4,
    parameter int PW       = 2,
    parameter int DWELL    = 60,
    parameter int VPP      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          next,
`ifdef VIDEO_PATTERN_SCHEDULER_PREV_EN
    input  logic          prev,
`endif
    input  logic          auto_en,
    input  logic          gray_req,
    output logic [PW-1:0] pattern,
    output logic          gray,
    output logic          gen_rst,
    output logic          busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        SWITCH  = 2'd2
    } state_t;

    localparam logic          VS_ACT     = (VPP != 0) ? 1'b1 : 1'b0;
    localparam logic [15:0]   DWELL_LAST = 16'(DWELL - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(PATTERNS - 1);
    localparam logic [PW-1:0] PAT_ONE    = PW'(1);

    state_t        state;
    state_t        state_nxt;
    logic          vsync_prev;
    logic          fb;
    logic [15:0]   dwell_cnt;
    logic          auto_req;
    logic          man_req;
    logic [PW-1:0] pat_inc;
    logic [PW-1:0] pat_step;

    assign fb       = (vsync == VS_ACT) && (vsync_prev != VS_ACT);
    assign auto_req = auto_en && fb && (dwell_cnt == DWELL_LAST) && (state == RUN);
    assign pat_inc  = (pattern == PAT_LAST) ? '0 : pattern + PAT_ONE;

`ifdef VIDEO_PATTERN_SCHEDULER_PREV_EN
    logic          dir_back;
    logic [PW-1:0] pat_dec;

    assign man_req  = next || prev;
    assign pat_dec  = (pattern == '0) ? PAT_LAST : pattern - PAT_ONE;
    assign pat_step = dir_back ? pat_dec : pat_inc;

    // Direction is frozen when the request is accepted; next wins a tie and auto is always forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_back <= 1'b0;
        end else if (state == RUN) begin
            dir_back <= prev && !next && !auto_req;
        end
    end
`else
    assign man_req  = next;
    assign pat_step = pat_inc;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        gen_rst   = 1'b0;
        case (state)
            RUN: begin
                if (man_req || auto_req) begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (fb) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH: begin
                busy      = 1'b1;
                gen_rst   = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            vsync_prev <= ~VS_ACT;
            pattern    <= '0;
            gray       <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            vsync_prev <= vsync;
            if (fb) begin
                gray <= gray_req;
            end
            if (state == SWITCH) begin
                pattern <= pat_step;
            end
            // The counter only advances in RUN/PENDING; an auto request or a switch restarts the dwell.
            if (!auto_en || (state == SWITCH) || auto_req) begin
                dwell_cnt <= '0;
            end else if (fb) begin
                dwell_cnt <= dwell_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Directed bench for video_pattern_scheduler; pattern updates are checked through a scoreboard queue.
module tb_video_pattern_scheduler;

    localparam int PATTERNS = 4;
    localparam int PW       = 2;
    localparam int DWELL    = 3;

    logic          clk;
    logic          rst;
    logic          vsync;
    logic          next;
    logic          prev;
    logic          auto_en;
    logic          gray_req;
    logic [PW-1:0] pattern;
    logic          gray;
    logic          gen_rst;
    logic          busy;

    int unsigned   n_cmp;
    int unsigned   n_bad;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pat;
    logic          sw_seen;

    video_pattern_scheduler #(
        .PATTERNS(PATTERNS),
        .PW      (PW),
        .DWELL   (DWELL),
        .VPP     (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .vsync   (vsync),
        .next    (next),
`ifdef VIDEO_PATTERN_SCHEDULER_PREV_EN
        .prev    (prev),
`endif
        .auto_en (auto_en),
        .gray_req(gray_req),
        .pattern (pattern),
        .gray    (gray),
        .gen_rst (gen_rst),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] fwd(input logic [PW-1:0] p);
        return (p == PW'(PATTERNS - 1)) ? '0 : p + PW'(1);
    endfunction

    task automatic frame();
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        step(4);
    endtask

    task automatic advance();
        next = 1'b1;
        step(1);
        next = 1'b0;
        step(3);
        exp_pat = fwd(exp_pat);
        exp_q.push_back(exp_pat);
        frame();
    endtask

    // One cycle after each gen_rst pulse the new pattern must match the oldest queued expectation.
    always @(negedge clk) begin
        if (sw_seen) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_unexpected_switch: observed pattern %0d expected no switch", pattern);
            end
            if (exp_q.size() != 0) begin
                chk("sb_pattern", 32'(pattern), 32'(exp_q.pop_front()));
            end
        end
        if (rst === 1'b0) begin
            chk("pattern_range", 32'(pattern < PW'(PATTERNS - 1) || pattern == PW'(PATTERNS - 1)), 32'd1);
        end
        sw_seen = (gen_rst === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        sw_seen  = 1'b0;
        exp_pat  = '0;
        rst      = 1'b1;
        vsync    = 1'b0;
        next     = 1'b0;
        prev     = 1'b0;
        auto_en  = 1'b0;
        gray_req = 1'b0;
        step(3);
        chk("rst_pattern", 32'(pattern), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gen_rst", 32'(gen_rst), 32'd0);
        chk("rst_gray", 32'(gray), 32'd0);
        chk("rst_dwell", 32'(dut.dwell_cnt), 32'd0);
        rst = 1'b0;

        // Request at cycle 10, frame boundary at cycle 50.
        step(9);
        next = 1'b1;
        step(1);
        next = 1'b0;
        for (int i = 11; i < 50; i++) begin
            chk("pend_busy", 32'(busy), 32'd1);
            step(1);
        end
        chk("pend_pattern", 32'(pattern), 32'd0);
        exp_pat = fwd(exp_pat);
        exp_q.push_back(exp_pat);
        vsync = 1'b1;
        step(1);
        chk("switch_gen_rst", 32'(gen_rst), 32'd1);
        chk("switch_busy", 32'(busy), 32'd1);
        chk("switch_pattern_old", 32'(pattern), 32'd0);
        vsync = 1'b0;
        step(1);
        chk("post_pattern", 32'(pattern), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_gen_rst", 32'(gen_rst), 32'd0);

        // Wrap from the last pattern; extra requests while pending are dropped.
        advance();
        advance();
        chk("at_last", 32'(pattern), 32'd3);
        next = 1'b1;
        step(1);
        next = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            next = 1'b1;
            step(1);
            next = 1'b0;
            step(1);
        end
        exp_pat = fwd(exp_pat);
        exp_q.push_back(exp_pat);
        frame();
        chk("wrap_pattern", 32'(pattern), 32'd0);
        chk("wrap_busy", 32'(busy), 32'd0);
        frame();
        chk("single_step", 32'(pattern), 32'd0);

        // Boundary in the request cycle is not consumed.
        next  = 1'b1;
        vsync = 1'b1;
        step(1);
        next  = 1'b0;
        vsync = 1'b0;
        chk("same_cycle_busy", 32'(busy), 32'd1);
        step(3);
        chk("same_cycle_hold", 32'(pattern), 32'd0);
        exp_pat = fwd(exp_pat);
        exp_q.push_back(exp_pat);
        frame();
        chk("same_cycle_next_fb", 32'(pattern), 32'd1);

        // Grayscale only follows the request on a frame boundary.
        gray_req = 1'b1;
        step(3);
        chk("gray_mid_frame", 32'(gray), 32'd0);
        vsync = 1'b1;
        step(1);
        chk("gray_at_fb", 32'(gray), 32'd1);
        vsync = 1'b0;
        step(3);
        gray_req = 1'b0;
        step(2);
        chk("gray_hold", 32'(gray), 32'd1);
        frame();
        chk("gray_clear", 32'(gray), 32'd0);

        // Reset while pending discards the request.
        next = 1'b1;
        step(1);
        next = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_pend_busy", 32'(busy), 32'd0);
        chk("rst_pend_pattern", 32'(pattern), 32'd0);
        exp_pat = '0;
        frame();
        frame();
        chk("rst_pend_no_switch", 32'(pattern), 32'd0);
        chk("rst_pend_idle", 32'(busy), 32'd0);

        // Reset during the switch cycle wins over the pattern update.
        next = 1'b1;
        step(1);
        next = 1'b0;
        step(2);
        vsync = 1'b1;
        step(1);
        vsync = 1'b0;
        chk("rst_sw_gen_rst", 32'(gen_rst), 32'd1);
        exp_q.push_back('0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_sw_pattern", 32'(pattern), 32'd0);
        chk("rst_sw_busy", 32'(busy), 32'd0);
        step(3);

        // Auto cycling: DWELL boundaries to request, one more to switch.
        auto_en = 1'b1;
        step(1);
        chk("auto_dwell_start", 32'(dut.dwell_cnt), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            if (i % 4 == 0) begin
                exp_pat = fwd(exp_pat);
                exp_q.push_back(exp_pat);
            end
            frame();
        end
        chk("auto_pattern", 32'(pattern), 32'd3);
        chk("auto_dwell_after", 32'(dut.dwell_cnt), 32'd0);
        frame();
        frame();
        chk("auto_dwell_two", 32'(dut.dwell_cnt), 32'd2);
        auto_en = 1'b0;
        step(1);
        chk("auto_off_dwell", 32'(dut.dwell_cnt), 32'd0);
        repeat (6) frame();
        chk("auto_off_pattern", 32'(pattern), 32'd3);
        chk("auto_off_dwell_end", 32'(dut.dwell_cnt), 32'd0);

`ifdef VIDEO_PATTERN_SCHEDULER_PREV_EN
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_pat = '0;
        prev = 1'b1;
        step(1);
        prev = 1'b0;
        step(2);
        exp_pat = PW'(PATTERNS - 1);
        exp_q.push_back(exp_pat);
        frame();
        chk("prev_wrap", 32'(pattern), 32'd3);
        next = 1'b1;
        prev = 1'b1;
        step(1);
        next = 1'b0;
        prev = 1'b0;
        step(2);
        exp_pat = fwd(exp_pat);
        exp_q.push_back(exp_pat);
        frame();
        chk("next_prev_tie", 32'(pattern), 32'd0);
        prev = 1'b1;
        step(1);
        prev = 1'b0;
        next = 1'b1;
        step(1);
        next = 1'b0;
        step(1);
        exp_pat = PW'(PATTERNS - 1);
        exp_q.push_back(exp_pat);
        frame();
        chk("prev_dir_latched", 32'(pattern), 32'd3);
`endif

        step(5);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
